// File: rtl/muu_mcfifo.sv
// Multi-channel FIFO: 2**USER_BITS independent circular buffers sharing one write port and one read port.
// Define MUU_MCFIFO_AUTOSEL_EN to replace m_axis_tusersel with a round-robin read-channel arbiter.
module muu_mcfifo #(
   parameter int DATA_SIZE = 64,
   parameter int ADDR_BITS = 5,
   parameter int USER_BITS = 3,
   parameter int AF_MARGIN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [USER_BITS-1:0]    s_axis_tusersel,
   input  logic [DATA_SIZE-1:0]    s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic                    s_axis_talmostfull,
   input  logic [USER_BITS-1:0]    m_axis_tusersel,
   output logic [DATA_SIZE-1:0]    m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [USER_BITS-1:0]    m_axis_tuser,
   output logic [2**USER_BITS-1:0] chan_empty,
   output logic [2**USER_BITS-1:0] chan_full
);

   localparam int NCH   = 2**USER_BITS;
   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0]   FULL_CNT  = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   AF_THRESH = (ADDR_BITS+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

   logic [DATA_SIZE-1:0] r_mem   [NCH][DEPTH];
   logic [ADDR_BITS-1:0] r_wptr  [NCH];
   logic [ADDR_BITS-1:0] r_rptr  [NCH];
   logic [ADDR_BITS:0]   r_count [NCH];
   logic [ADDR_BITS:0]   w_count_nxt [NCH];
   logic [NCH-1:0]       r_empty, r_full;
   logic [NCH-1:0]       w_empty_nxt, w_full_nxt;
   logic [USER_BITS-1:0] r_ssel, r_msel;
   logic                 w_wr, w_rd;

   // Handshake outputs are gated by rst so they read inactive the moment reset asserts.
   assign s_axis_tready      = rst & ~r_full[r_ssel];
   assign s_axis_talmostfull = rst & (r_count[r_ssel] >= AF_THRESH);
   assign m_axis_tvalid      = rst & ~r_empty[r_msel];
   assign m_axis_tdata       = r_mem[r_msel][r_rptr[r_msel]];
   assign m_axis_tuser       = r_msel;
   assign chan_empty         = r_empty;
   assign chan_full          = r_full;

   assign w_wr = s_axis_tvalid & s_axis_tready;
   assign w_rd = m_axis_tvalid & m_axis_tready;

   // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_count_nxt[i] = r_count[i];
         if (w_wr && (r_ssel == USER_BITS'(i))) w_count_nxt[i] = w_count_nxt[i] + CNT_ONE;
         if (w_rd && (r_msel == USER_BITS'(i))) w_count_nxt[i] = w_count_nxt[i] - CNT_ONE;
         w_empty_nxt[i] = (w_count_nxt[i] == '0);
         w_full_nxt[i]  = (w_count_nxt[i] == FULL_CNT);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
         end
         r_empty <= '1;
         r_full  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_wr && (r_ssel == USER_BITS'(i))) r_wptr[i] <= r_wptr[i] + PTR_ONE;
            if (w_rd && (r_msel == USER_BITS'(i))) r_rptr[i] <= r_rptr[i] + PTR_ONE;
            r_count[i] <= w_count_nxt[i];
         end
         r_empty <= w_empty_nxt;
         r_full  <= w_full_nxt;
      end
   end

   // NOTE: the storage array has no reset; emptiness is tracked by the counts, so stale words are never presented.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_ssel][r_wptr[r_ssel]] <= s_axis_tdata;
   end

`ifdef MUU_MCFIFO_AUTOSEL_EN
   logic [USER_BITS-1:0] w_msel_nxt;

   // Search the channels after r_msel in wrap order; offset NCH lands back on r_msel itself.
   always_comb begin : rr_search
      logic [USER_BITS-1:0] cand;
      logic                 found;
      cand       = r_msel;
      found      = 1'b0;
      w_msel_nxt = r_msel;
      for (int k = 1; k <= NCH; k++) begin
         cand = r_msel + USER_BITS'(k);
         if (!found && !r_empty[cand]) begin
            w_msel_nxt = cand;
            found      = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ssel <= '0;
         r_msel <= '0;
      end else begin
         if (!s_axis_tvalid) r_ssel <= s_axis_tusersel;
`ifdef MUU_MCFIFO_AUTOSEL_EN
         // Empty selection or completed read moves on; a stalled valid word holds msel.
         if (w_rd || r_empty[r_msel]) r_msel <= w_msel_nxt;
`else
         if (!m_axis_tready) r_msel <= m_axis_tusersel;
`endif
      end
   end

endmodule

// File: tb/tb_muu_mcfifo.sv
// Directed bench for muu_mcfifo (depth 4, 8 channels, almost-full at 3) with per-channel scoreboard queues.
module tb_muu_mcfifo;

   localparam int DS    = 16;
   localparam int AB    = 2;
   localparam int UB    = 3;
   localparam int AFM   = 1;
   localparam int NCH   = 2**UB;
   localparam int DEPTH = 2**AB;

   logic           clk = 1'b0;
   logic           rst;
   logic [UB-1:0]  s_sel, m_sel, m_user;
   logic [DS-1:0]  s_data, m_data;
   logic           s_valid, s_ready, s_af, m_valid, m_ready;
   logic [NCH-1:0] c_empty, c_full;

   int n_total = 0;
   int n_bad   = 0;
   logic [DS-1:0] sb [NCH][$];

   always #5 clk = ~clk;

   muu_mcfifo #(.DATA_SIZE(DS), .ADDR_BITS(AB), .USER_BITS(UB), .AF_MARGIN(AFM)) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_tusersel    (s_sel),
      .s_axis_tdata       (s_data),
      .s_axis_tvalid      (s_valid),
      .s_axis_tready      (s_ready),
      .s_axis_talmostfull (s_af),
      .m_axis_tusersel    (m_sel),
      .m_axis_tdata       (m_data),
      .m_axis_tvalid      (m_valid),
      .m_axis_tready      (m_ready),
      .m_axis_tuser       (m_user),
      .chan_empty         (c_empty),
      .chan_full          (c_full)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH-1:0] exp_empty();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = (sb[i].size() == 0);
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_full();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = (sb[i].size() == DEPTH);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Select channel with valid low, then offer n consecutive words one per cycle.
   task automatic wr_burst(input int ch, input int n, input logic [DS-1:0] base);
      s_valid = 1'b0;
      s_sel   = ch[UB-1:0];
      tick();
      s_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         s_data = base + DS'(i);
         check("wr_ready", s_ready, sb[ch].size() < DEPTH);
         check("wr_full", c_full, exp_full());
         if (sb[ch].size() < DEPTH) sb[ch].push_back(s_data);
         tick();
      end
      s_valid = 1'b0;
      check("wr_af", s_af, sb[ch].size() >= DEPTH - AFM);
      check("wr_empty", c_empty, exp_empty());
   endtask

   task automatic rd(input int ch, input int n);
      m_ready = 1'b0;
      m_sel   = ch[UB-1:0];
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check("rd_user", m_user, ch[UB-1:0]);
         check("rd_valid", m_valid, sb[ch].size() != 0);
         if (sb[ch].size() != 0) begin
            check("rd_data", m_data, sb[ch][0]);
            void'(sb[ch].pop_front());
         end
         tick();
      end
      m_ready = 1'b0;
      check("rd_empty", c_empty, exp_empty());
      check("rd_full", c_full, exp_full());
   endtask

   // Concurrent write to wch and read from rch for n cycles.
   task automatic both(input int wch, input int rch, input int n, input logic [DS-1:0] base);
      logic w_ok, r_ok;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_sel   = wch[UB-1:0];
      m_sel   = rch[UB-1:0];
      tick();
      s_valid = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         s_data = base + DS'(i);
         w_ok   = sb[wch].size() < DEPTH;
         r_ok   = sb[rch].size() != 0;
         check("both_ready", s_ready, w_ok);
         check("both_valid", m_valid, r_ok);
         if (r_ok) begin
            check("both_data", m_data, sb[rch][0]);
            void'(sb[rch].pop_front());
         end
         if (w_ok) sb[wch].push_back(s_data);
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      check("both_empty", c_empty, exp_empty());
      check("both_full", c_full, exp_full());
   endtask

`ifdef MUU_MCFIFO_AUTOSEL_EN
   int seq [6] = '{1, 4, 6, 1, 4, 6};
`endif

   initial begin
      rst     = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_sel   = '0;
      m_sel   = '0;
      s_data  = '0;
      tick();
      tick();
      check("rst_empty", c_empty, {NCH{1'b1}});
      check("rst_full", c_full, {NCH{1'b0}});
      check("rst_ready", s_ready, 1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_af", s_af, 1'b0);
      check("rst_user", m_user, {UB{1'b0}});
      rst = 1'b1;
      #1;
      check("rel_ready", s_ready, 1'b1);

`ifdef MUU_MCFIFO_AUTOSEL_EN
      wr_burst(1, 2, 16'h1100);
      wr_burst(4, 2, 16'h4400);
      wr_burst(6, 2, 16'h6600);
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("rr_user", m_user, seq[i][UB-1:0]);
         check("rr_valid", m_valid, 1'b1);
         check("rr_data", m_data, sb[seq[i]][0]);
         void'(sb[seq[i]].pop_front());
         tick();
      end
      m_ready = 1'b0;
      check("rr_empty", c_empty, exp_empty());
`else
      // Fill channel 3 to full, fifth word stalls, drain in order.
      wr_burst(3, 5, 16'h00A0);
      check("full3", c_full, 8'b0000_1000);
      rd(3, 5);
      // Almost-full at three words, clears after one read.
      wr_burst(1, 3, 16'h0B10);
      s_sel = 3'd1;
      rd(1, 1);
      check("af_clear", s_af, 1'b0);
      rd(1, 2);
      // Full channel 2 does not stall channel 5.
      wr_burst(2, 4, 16'h2200);
      wr_burst(5, 4, 16'h5500);
      rd(5, 4);
      rd(2, 4);
      // Same-channel write+read holds count at two.
      wr_burst(0, 2, 16'h0C00);
      both(0, 0, 10, 16'h0D00);
      rd(0, 3);
      // Write and read on different channels update independently.
      wr_burst(7, 2, 16'h7700);
      both(6, 7, 3, 16'h6600);
      rd(6, 4);
`endif

      // Mid-operation reset discards contents of three channels.
      wr_burst(1, 2, 16'hE100);
      wr_burst(2, 1, 16'hE200);
      wr_burst(3, 3, 16'hE300);
      rst = 1'b0;
      #1;
      check("mid_rst_empty", c_empty, {NCH{1'b1}});
      check("mid_rst_valid", m_valid, 1'b0);
      check("mid_rst_ready", s_ready, 1'b0);
      check("mid_rst_full", c_full, {NCH{1'b0}});
      for (int i = 0; i < NCH; i++) sb[i].delete();
      tick();
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      #1;
      check("post_rst_ready", s_ready, 1'b1);
      sb[0].push_back(s_data);
      tick();
      s_valid = 1'b0;
      check("post_rst_empty", c_empty, exp_empty());
`ifndef MUU_MCFIFO_AUTOSEL_EN
      rd(1, 1);
      rd(0, 2);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
